// File: rtl/comparador_magnitud_pipe.sv
`default_nettype none
// comparador_magnitud_pipe: two-stage unsigned / two's-complement / sign-magnitude comparator.
// Rev 1.0 - stage 1 slice compares, stage 2 priority combine with MAX/MIN select.
module comparador_magnitud_pipe #(
  parameter int W     = 32,
  parameter int CHUNK = 8
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         IN_VALID,
  input  logic         STALL,
  input  logic [1:0]   MODE,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  output logic         OUT_VALID,
  output logic         GT,
  output logic         EQ,
  output logic         LT,
  output logic [W-1:0] MAX,
  output logic [W-1:0] MIN
);

  localparam int NC = (W + CHUNK - 1) / CHUNK;

  logic [W-1:0]  key_a, key_b;
  logic          is_sm;
  logic [NC-1:0] sl_gt, sl_eq;

  // Signed: MSB flip maps two's-complement order onto unsigned order.
  // Sign-magnitude: the sign is stripped here and re-applied in stage 2.
  always_comb begin
    is_sm = (MODE == 2'b10);
    key_a = A;
    key_b = B;
    if (MODE == 2'b01) begin
      key_a[W-1] = ~A[W-1];
      key_b[W-1] = ~B[W-1];
    end else if (is_sm) begin
      key_a[W-1] = 1'b0;
      key_b[W-1] = 1'b0;
    end
  end

  for (genvar gi = 0; gi < NC; gi++) begin : g_slice
    localparam int LO = gi * CHUNK;
    localparam int HI = (LO + CHUNK > W) ? W - 1 : LO + CHUNK - 1;
    assign sl_gt[gi] = key_a[HI:LO] >  key_b[HI:LO];
    assign sl_eq[gi] = key_a[HI:LO] == key_b[HI:LO];
  end

  logic          v1_q, v1_d;
  logic [NC-1:0] gt1_q, gt1_d, eq1_q, eq1_d;
  logic          zero_both_q, zero_both_d, sign_a_q, sign_a_d, sign_b_q, sign_b_d;
  logic [W-1:0]  a1_q, a1_d, b1_q, b1_d;

  always_comb begin
    v1_d        = v1_q;
    gt1_d       = gt1_q;
    eq1_d       = eq1_q;
    zero_both_d = zero_both_q;
    sign_a_d    = sign_a_q;
    sign_b_d    = sign_b_q;
    a1_d        = a1_q;
    b1_d        = b1_q;
    if (!STALL) begin
      v1_d = IN_VALID;
      if (IN_VALID) begin
        gt1_d       = sl_gt;
        eq1_d       = sl_eq;
        zero_both_d = is_sm && (A[W-2:0] == '0) && (B[W-2:0] == '0);
        sign_a_d    = is_sm && A[W-1];
        sign_b_d    = is_sm && B[W-1];
        a1_d        = A;
        b1_d        = B;
      end
    end
  end

  logic mag_gt, mag_eq, res_gt, res_eq, res_lt;

  // Ascending scan: the highest unequal slice is the last writer and wins.
  always_comb begin
    mag_gt = 1'b0;
    mag_eq = 1'b1;
    for (int i = 0; i < NC; i++) begin
      if (!eq1_q[i]) begin
        mag_gt = gt1_q[i];
        mag_eq = 1'b0;
      end
    end
    res_gt = mag_gt;
    res_eq = mag_eq;
    res_lt = !mag_gt && !mag_eq;
    if (zero_both_q) begin
      res_gt = 1'b0;
      res_eq = 1'b1;
      res_lt = 1'b0;
    end else if (sign_a_q != sign_b_q) begin
      res_gt = !sign_a_q;
      res_eq = 1'b0;
      res_lt = sign_a_q;
    end else if (sign_a_q) begin
      res_gt = !mag_gt && !mag_eq;
      res_lt = mag_gt;
    end
  end

  logic         out_valid_q, out_valid_d, gt_q, gt_d, eq_q, eq_d, lt_q, lt_d;
  logic [W-1:0] max_q, max_d, min_q, min_d;

  always_comb begin
    out_valid_d = out_valid_q;
    gt_d        = gt_q;
    eq_d        = eq_q;
    lt_d        = lt_q;
    max_d       = max_q;
    min_d       = min_q;
    if (!STALL) begin
      out_valid_d = v1_q;
      if (v1_q) begin
        gt_d  = res_gt;
        eq_d  = res_eq;
        lt_d  = res_lt;
        max_d = res_lt ? b1_q : a1_q;
        min_d = res_lt ? a1_q : b1_q;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      v1_q        <= 1'b0;
      gt1_q       <= '0;
      eq1_q       <= '0;
      zero_both_q <= 1'b0;
      sign_a_q    <= 1'b0;
      sign_b_q    <= 1'b0;
      a1_q        <= '0;
      b1_q        <= '0;
      out_valid_q <= 1'b0;
      gt_q        <= 1'b0;
      eq_q        <= 1'b0;
      lt_q        <= 1'b0;
      max_q       <= '0;
      min_q       <= '0;
    end else begin
      v1_q        <= v1_d;
      gt1_q       <= gt1_d;
      eq1_q       <= eq1_d;
      zero_both_q <= zero_both_d;
      sign_a_q    <= sign_a_d;
      sign_b_q    <= sign_b_d;
      a1_q        <= a1_d;
      b1_q        <= b1_d;
      out_valid_q <= out_valid_d;
      gt_q        <= gt_d;
      eq_q        <= eq_d;
      lt_q        <= lt_d;
      max_q       <= max_d;
      min_q       <= min_d;
    end
  end

  assign OUT_VALID = out_valid_q;
  assign GT        = gt_q;
  assign EQ        = eq_q;
  assign LT        = lt_q;
  assign MAX       = max_q;
  assign MIN       = min_q;

endmodule
`default_nettype wire

// File: tb/tb_comparador_magnitud_pipe.sv
`default_nettype none
// tb_comparador_magnitud_pipe: three widths (8/4, 13/4, 32/8) driven in lockstep and
// checked against an integer-ordering reference model, plus directed vectors.
module tb_comparador_magnitud_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        stall = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [31:0] a_in = '0, b_in = '0;

  always #5 clk = ~clk;

  logic        ov8, gt8, eq8, lt8, ov13, gt13, eq13, lt13, ov32, gt32, eq32, lt32;
  logic [7:0]  mx8, mn8;
  logic [12:0] mx13, mn13;
  logic [31:0] mx32, mn32;

  comparador_magnitud_pipe #(.W(8), .CHUNK(4)) dut8 (
    .CLK(clk), .RST(rst_n), .IN_VALID(in_valid), .STALL(stall), .MODE(mode),
    .A(a_in[7:0]), .B(b_in[7:0]), .OUT_VALID(ov8), .GT(gt8), .EQ(eq8), .LT(lt8),
    .MAX(mx8), .MIN(mn8));

  comparador_magnitud_pipe #(.W(13), .CHUNK(4)) dut13 (
    .CLK(clk), .RST(rst_n), .IN_VALID(in_valid), .STALL(stall), .MODE(mode),
    .A(a_in[12:0]), .B(b_in[12:0]), .OUT_VALID(ov13), .GT(gt13), .EQ(eq13), .LT(lt13),
    .MAX(mx13), .MIN(mn13));

  comparador_magnitud_pipe #(.W(32), .CHUNK(8)) dut32 (
    .CLK(clk), .RST(rst_n), .IN_VALID(in_valid), .STALL(stall), .MODE(mode),
    .A(a_in), .B(b_in), .OUT_VALID(ov32), .GT(gt32), .EQ(eq32), .LT(lt32),
    .MAX(mx32), .MIN(mn32));

  // Packed view: [67]=valid [66]=gt [65]=eq [64]=lt [63:32]=max [31:0]=min
  logic [67:0] res [3];
  assign res[0] = {ov8,  gt8,  eq8,  lt8,  24'd0, mx8,  24'd0, mn8};
  assign res[1] = {ov13, gt13, eq13, lt13, 19'd0, mx13, 19'd0, mn13};
  assign res[2] = {ov32, gt32, eq32, lt32, mx32, mn32};

  typedef struct {
    int         due;
    logic [1:0] mode;
    logic [31:0] a;
    logic [31:0] b;
  } acc_t;

  typedef struct {
    int          w;
    logic [1:0]  mode;
    logic [31:0] a;
    logic [31:0] b;
    logic        gt;
    logic        eq;
    logic        lt;
    logic [31:0] mx;
    logic [31:0] mn;
  } vec_t;

  acc_t        sb[$];
  int          tests = 0, failed = 0;
  int          nsc = 0;
  bit          last_stall = 1'b0;
  logic [67:0] snap [3];
  bit          snap_ok = 1'b0;
  int          ov_cnt;
  logic [31:0] ra, rb;
  vec_t        tbl [12];

  function automatic int wid(int k);
    return (k == 0) ? 8 : (k == 1) ? 13 : 32;
  endfunction

  function automatic logic [31:0] mask32(int w);
    return (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction

  // Numeric value of a w-bit pattern under a mode; -0 and +0 both map to 0.
  function automatic longint keyval(logic [1:0] m, logic [31:0] x, int w);
    longint u, half, mag;
    u    = longint'(x & mask32(w));
    half = longint'(1) << (w - 1);
    mag  = u % half;
    case (m)
      2'b01:   return (u >= half) ? u - 2 * half : u;
      2'b10:   return (u >= half) ? -mag : mag;
      default: return u;
    endcase
  endfunction

  function automatic logic [67:0] expect_res(acc_t e, int w);
    logic [31:0] ae, be;
    longint va, vb;
    logic g, q, l;
    ae = e.a & mask32(w);
    be = e.b & mask32(w);
    va = keyval(e.mode, ae, w);
    vb = keyval(e.mode, be, w);
    g  = va > vb;
    q  = va == vb;
    l  = va < vb;
    return {1'b1, g, q, l, (l ? be : ae), (l ? ae : be)};
  endfunction

  task automatic check(string name, int k, logic [67:0] act, logic [67:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s dut_w%0d: got %h expected %h", name, wid(k), act, exp);
    end
  endtask

  task automatic monitor();
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) begin
        check("reset_zero", k, res[k], 68'd0);
      end else if (last_stall && snap_ok) begin
        check("stall_hold", k, res[k], snap[k]);
      end else if (res[k][67]) begin
        if (sb.size() == 0) begin
          tests++;
          failed++;
          $display("FAIL spurious_valid dut_w%0d: got out_valid=1 expected out_valid=0", wid(k));
        end else begin
          check("latency", k, 68'(nsc), 68'(sb[0].due));
          check("result", k, res[k], expect_res(sb[0], wid(k)));
        end
      end else begin
        if (sb.size() > 0 && sb[0].due <= nsc) begin
          tests++;
          failed++;
          $display("FAIL dropped dut_w%0d: got out_valid=0 expected out_valid=1", wid(k));
        end
        if (snap_ok) check("idle_hold", k, res[k], {1'b0, snap[k][66:0]});
      end
    end
    if (rst_n && !last_stall && res[2][67] && sb.size() > 0) void'(sb.pop_front());
    snap    = res;
    snap_ok = rst_n;
  endtask

  // One clock: log acceptance at the rising edge, check on the falling edge.
  task automatic cycle();
    @(posedge clk);
    if (rst_n) begin
      last_stall = stall;
      if (!stall) begin
        nsc++;
        if (in_valid) sb.push_back('{nsc + 1, mode, a_in, b_in});
      end
    end else begin
      last_stall = 1'b0;
    end
    @(negedge clk);
    monitor();
  endtask

  task automatic drive(logic [1:0] m, logic [31:0] a, logic [31:0] b);
    in_valid = 1'b1;
    mode     = m;
    a_in     = a;
    b_in     = b;
  endtask

  initial begin
    tbl[0]  = '{8,  2'b00, 32'h80, 32'h7F, 1, 0, 0, 32'h80, 32'h7F};
    tbl[1]  = '{8,  2'b01, 32'h80, 32'h7F, 0, 0, 1, 32'h7F, 32'h80};
    tbl[2]  = '{8,  2'b10, 32'h80, 32'h7F, 0, 0, 1, 32'h7F, 32'h80};
    tbl[3]  = '{8,  2'b10, 32'h80, 32'h00, 0, 1, 0, 32'h80, 32'h00};
    tbl[4]  = '{8,  2'b10, 32'h85, 32'h83, 0, 0, 1, 32'h83, 32'h85};
    tbl[5]  = '{32, 2'b10, 32'h3F80_0000, 32'hBF80_0000, 1, 0, 0, 32'h3F80_0000, 32'hBF80_0000};
    tbl[6]  = '{32, 2'b10, 32'h4000_0001, 32'h4000_0000, 1, 0, 0, 32'h4000_0001, 32'h4000_0000};
    tbl[7]  = '{8,  2'b11, 32'hFF, 32'h01, 1, 0, 0, 32'hFF, 32'h01};
    tbl[8]  = '{32, 2'b01, 32'hFFFF_FFFF, 32'h1, 0, 0, 1, 32'h1, 32'hFFFF_FFFF};
    tbl[9]  = '{32, 2'b10, 32'h8000_0000, 32'h0, 0, 1, 0, 32'h8000_0000, 32'h0};
    tbl[10] = '{13, 2'b01, 32'h1000, 32'h0FFF, 0, 0, 1, 32'h0FFF, 32'h1000};
    tbl[11] = '{13, 2'b00, 32'h1ABC, 32'h1ABC, 0, 1, 0, 32'h1ABC, 32'h1ABC};

    cycle();
    cycle();
    rst_n = 1'b1;

    // Directed vectors, one at a time.
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].mode, tbl[i].a, tbl[i].b);
      cycle();
      in_valid = 1'b0;
      cycle();
      check($sformatf("vec%0d", i), (tbl[i].w == 8) ? 0 : (tbl[i].w == 13) ? 1 : 2,
            res[(tbl[i].w == 8) ? 0 : (tbl[i].w == 13) ? 1 : 2],
            {1'b1, tbl[i].gt, tbl[i].eq, tbl[i].lt, tbl[i].mx, tbl[i].mn});
    end

    // Four back-to-back operands with alternating modes.
    ov_cnt = 0;
    for (int i = 0; i < 7; i++) begin
      if (i < 4) drive((i % 2 == 0) ? 2'b10 : 2'b01, $urandom, $urandom);
      else in_valid = 1'b0;
      cycle();
      if (ov32) ov_cnt++;
    end
    check("stream_ov_count", 2, 68'(ov_cnt), 68'd4);

    // Two results in flight, then a 3-cycle stall with a pending operand.
    drive(2'b00, 32'h1234_5678, 32'h1234_5679);
    cycle();
    drive(2'b10, 32'h8000_0005, 32'h0000_0003);
    cycle();
    drive(2'b01, 32'hDEAD_BEEF, 32'h0BAD_F00D);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    stall    = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) cycle();

    // Reset pulse while one result is visible and another is in stage 1.
    drive(2'b00, 32'h0000_00F0, 32'h0000_000F);
    cycle();
    drive(2'b01, 32'h0000_0001, 32'hFFFF_FFFF);
    cycle();
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) check("async_reset", k, res[k], 68'd0);
    sb.delete();
    snap_ok = 1'b0;
    #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) cycle();

    // Randomised traffic with bubbles, stalls and all modes.
    for (int i = 0; i < 500; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 4))
        0: rb = $urandom;
        1: rb = ra;
        2: rb = ra ^ 32'h1;
        3: rb = ra ^ 32'h8000_1080;
        default: begin
          ra = (($urandom_range(0, 1) != 0) ? 32'h8000_1080 : 32'h0);
          rb = (($urandom_range(0, 1) != 0) ? 32'h8000_1080 : 32'h0);
        end
      endcase
      in_valid = ($urandom_range(0, 3) != 0);
      stall    = ($urandom_range(0, 6) == 0);
      mode     = 2'($urandom_range(0, 3));
      a_in     = ra;
      b_in     = rb;
      cycle();
    end
    in_valid = 1'b0;
    stall    = 1'b0;
    for (int i = 0; i < 4; i++) cycle();
    check("drain_empty", 2, 68'(sb.size()), 68'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire
